// File: rtl/am_unit.sv
// am_unit: registered 4-bit ALU multiplexer with 16 operations.
// Each result is computed combinationally and captured in one output register stage.
module am_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic [3:0]  Sel,
  output logic [15:0] Out,
  output logic        Ovf
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011,
    OP_MOD = 4'b0100, OP_AND = 4'b0101, OP_OR  = 4'b0110, OP_XOR = 4'b0111,
    OP_NOT = 4'b1000, OP_SHL = 4'b1001, OP_SHR = 4'b1010, OP_POW = 4'b1011,
    OP_MAX = 4'b1100, OP_MIN = 4'b1101, OP_CMP = 4'b1110, OP_DEC = 4'b1111
  } op_e;

  logic [15:0] r_out;
  logic        r_ovf;

  logic [4:0]  w_sum;
  logic [7:0]  w_mul;
  logic [18:0] w_shl;
  logic [19:0] w_pow_acc;
  logic        w_pow_ovf;
  logic [15:0] w_res;
  logic        w_ovf;
  op_e         w_op;

  assign w_op  = op_e'(Sel);
  assign w_sum = {1'b0, A} + {1'b0, B};
  assign w_mul = {4'b0, A} * {4'b0, B};
  assign w_shl = {15'b0, A} << B;

  // Repeated multiply; once the product exceeds 16 bits it is pinned just
  // above the limit so the accumulator cannot grow past its 20-bit width.
  always_comb begin
    // NOTE: blocking assignments here because each loop pass must see the
    // previous pass's product; state registers below use non-blocking.
    w_pow_acc = 20'd1;
    w_pow_ovf = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (4'(i) < B) begin
        w_pow_acc = w_pow_acc * {16'b0, A};
        if (w_pow_acc > 20'h0FFFF) begin
          w_pow_ovf = 1'b1;
          w_pow_acc = 20'h10000;
        end
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_res = 16'h0000;
    w_ovf = 1'b0;
    case (w_op)
      OP_ADD: w_res = {11'b0, w_sum};
      OP_SUB: w_res = {12'b0, A} - {12'b0, B};
      OP_MUL: w_res = {8'b0, w_mul};
      OP_DIV: begin
        if (B == 4'd0) w_ovf = 1'b1;
        else           w_res = {12'b0, A / B};
      end
      OP_MOD: begin
        if (B == 4'd0) w_ovf = 1'b1;
        else           w_res = {12'b0, A % B};
      end
      OP_AND: w_res = {12'b0, A & B};
      OP_OR:  w_res = {12'b0, A | B};
      OP_XOR: w_res = {12'b0, A ^ B};
      OP_NOT: w_res = {12'b0, ~A};
      OP_SHL: begin
        if (|w_shl[18:16]) w_ovf = 1'b1;
        else               w_res = w_shl[15:0];
      end
      OP_SHR: w_res = {12'b0, A >> B};
      OP_POW: begin
        if (w_pow_ovf) w_ovf = 1'b1;
        else           w_res = w_pow_acc[15:0];
      end
      OP_MAX: w_res = {12'b0, (A > B) ? A : B};
      OP_MIN: w_res = {12'b0, (A < B) ? A : B};
      OP_CMP: w_res = {13'b0, A > B, A == B, A < B};
      OP_DEC: w_res = 16'h0001 << A;
      default: begin
        w_res = 16'h0000;
        w_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: only the output register exists, so reset covers all state;
    // inputs seen on a reset edge are simply dropped.
    if (rst) begin
      r_out <= 16'h0000;
      r_ovf <= 1'b0;
    end else begin
      r_out <= w_res;
      r_ovf <= w_ovf;
    end
  end

  assign Out = r_out;
  assign Ovf = r_ovf;

endmodule

// File: tb/tb_am_unit.sv
// tb_am_unit: directed vectors with hand-computed results for am_unit.
// Each check compares the packed {Ovf, Out} value one clock after the inputs are applied.
module tb_am_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  am_unit dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .Sel (sel),
    .Out (out),
    .Ovf (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ovf=%0b out=0x%04h, expected ovf=%0b out=0x%04h",
               tag, act[16], act[15:0], exp[16], exp[15:0]);
    end
  endtask

  // Present one operation, clock it, and sample 1 time unit after the edge.
  task automatic apply(input logic [3:0] a_v, input logic [3:0] b_v,
                       input logic [3:0] sel_v, input logic rst_v);
    a   = a_v;
    b   = b_v;
    sel = sel_v;
    rst = rst_v;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic [3:0] a_v, input logic [3:0] b_v,
                    input logic [3:0] sel_v, input logic exp_ovf, input logic [15:0] exp_out);
    apply(a_v, b_v, sel_v, 1'b0);
    check(tag, {ovf, out}, {exp_ovf, exp_out});
  endtask

  initial begin
    a = 4'hF; b = 4'hF; sel = 4'b0010; rst = 1'b1;

    // Reset held for two edges with a live multiply on the inputs.
    apply(4'hF, 4'hF, 4'b0010, 1'b1);
    check("reset_1", {ovf, out}, 17'h00000);
    apply(4'hF, 4'hF, 4'b0010, 1'b1);
    check("reset_2", {ovf, out}, 17'h00000);
    op("mul_15x15", 4'hF, 4'hF, 4'b0010, 1'b0, 16'h00E1);

    // Arithmetic
    op("add_9_6",   4'd9,  4'd6, 4'b0000, 1'b0, 16'h000F);
    op("sub_9_6",   4'd9,  4'd6, 4'b0001, 1'b0, 16'h0003);
    op("sub_3_5",   4'd3,  4'd5, 4'b0001, 1'b0, 16'hFFFE);
    op("add_15_15", 4'd15, 4'd15, 4'b0000, 1'b0, 16'h001E);
    op("div_13_4",  4'd13, 4'd4, 4'b0011, 1'b0, 16'h0003);
    op("mod_13_4",  4'd13, 4'd4, 4'b0100, 1'b0, 16'h0001);

    // Divide by zero, then immediate recovery
    op("div_7_0",   4'd7,  4'd0, 4'b0011, 1'b1, 16'h0000);
    op("mod_7_0",   4'd7,  4'd0, 4'b0100, 1'b1, 16'h0000);
    op("div_7_1",   4'd7,  4'd1, 4'b0011, 1'b0, 16'h0007);

    // Shift and power boundaries
    op("shl_1_15",  4'd1,  4'd15, 4'b1001, 1'b0, 16'h8000);
    op("shl_2_15",  4'd2,  4'd15, 4'b1001, 1'b1, 16'h0000);
    op("shl_15_15", 4'd15, 4'd15, 4'b1001, 1'b1, 16'h0000);
    op("shl_15_12", 4'd15, 4'd12, 4'b1001, 1'b0, 16'hF000);
    op("pow_2_15",  4'd2,  4'd15, 4'b1011, 1'b0, 16'h8000);
    op("pow_4_8",   4'd4,  4'd8,  4'b1011, 1'b1, 16'h0000);
    op("pow_0_0",   4'd0,  4'd0,  4'b1011, 1'b0, 16'h0001);
    op("pow_15_5",  4'd15, 4'd5,  4'b1011, 1'b1, 16'h0000);
    op("pow_3_10",  4'd3,  4'd10, 4'b1011, 1'b0, 16'hE6A9);
    op("pow_0_5",   4'd0,  4'd5,  4'b1011, 1'b0, 16'h0000);
    op("pow_15_4",  4'd15, 4'd4,  4'b1011, 1'b0, 16'hC5C1);

    // Logic, compare, decode
    op("and_a_6",   4'hA, 4'h6, 4'b0101, 1'b0, 16'h0002);
    op("or_a_6",    4'hA, 4'h6, 4'b0110, 1'b0, 16'h000E);
    op("xor_a_6",   4'hA, 4'h6, 4'b0111, 1'b0, 16'h000C);
    op("not_a",     4'hA, 4'h6, 4'b1000, 1'b0, 16'h0005);
    op("cmp_gt",    4'hA, 4'h6, 4'b1110, 1'b0, 16'h0004);
    op("cmp_eq",    4'd7, 4'd7, 4'b1110, 1'b0, 16'h0002);
    op("cmp_lt",    4'd2, 4'd9, 4'b1110, 1'b0, 16'h0001);
    op("dec_15",    4'd15, 4'd0, 4'b1111, 1'b0, 16'h8000);
    op("dec_0",     4'd0, 4'd3, 4'b1111, 1'b0, 16'h0001);

    // Outputs hold between edges even when inputs change mid-cycle
    a = 4'd3; b = 4'd3; sel = 4'b0000;
    #3;
    check("hold", {ovf, out}, {1'b0, 16'h0001});

    // Back-to-back stream: each result follows its own inputs by one edge
    op("stream_max", 4'd12, 4'd2, 4'b1100, 1'b0, 16'h000C);
    op("stream_min", 4'd12, 4'd2, 4'b1101, 1'b0, 16'h0002);
    op("stream_shr", 4'd12, 4'd2, 4'b1010, 1'b0, 16'h0003);

    // Same stream with reset asserted on the second operation
    op("mid_max", 4'd12, 4'd2, 4'b1100, 1'b0, 16'h000C);
    apply(4'd12, 4'd2, 4'b1101, 1'b1);
    check("mid_rst", {ovf, out}, 17'h00000);
    op("mid_shr", 4'd12, 4'd2, 4'b1010, 1'b0, 16'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
